// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : in-order instruction fetch queue between PC register and decode
// Rev 1.0
// ============================================================================
module fetch_queue #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_alloc;
    logic [AW-1:0]    r_fill;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] r_unf;

    logic w_credit;
    logic w_req_valid;
    logic w_accept;
    logic w_rsp_drop;
    logic w_rsp_fill;
    logic w_id_valid;
    logic w_pop;

    // Outstanding stale responses consume credit just like live entries.
    assign w_credit    = ({1'b0, r_occ} + {1'b0, r_drop}) < (CNT_W + 1)'(DEPTH);
    assign w_req_valid = rst_n & ~redirect_valid & w_credit;
    assign w_accept    = w_req_valid & imem_req_ready;
    assign w_rsp_drop  = imem_rsp_valid & (r_drop != '0);
    assign w_rsp_fill  = imem_rsp_valid & (r_drop == '0) & (r_unf != '0);
    assign w_id_valid  = rst_n & (r_occ != '0) & r_filled[r_head] & ~redirect_valid;
    assign w_pop       = w_id_valid & id_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = pc;
    assign id_valid       = w_id_valid;
    assign id_instr       = rst_n ? r_instr[r_head] : 32'h0;
    assign id_pc          = rst_n ? r_pc[r_head]    : 32'h0;

    always_comb begin
        pc_next = pc;
        if (rst_n) begin
            if (redirect_valid) begin
                pc_next = redirect_pc;
            end else if (w_accept) begin
                pc_next = pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_alloc  <= '0;
            r_fill   <= '0;
            r_occ    <= '0;
            r_drop   <= '0;
            r_unf    <= '0;
            r_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= 32'h0;
                r_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            r_head   <= '0;
            r_alloc  <= '0;
            r_fill   <= '0;
            r_occ    <= '0;
            r_unf    <= '0;
            r_filled <= '0;
            // A response arriving now belongs to a pre-redirect request too.
            r_drop   <= r_drop - CNT_W'(w_rsp_drop) + r_unf - CNT_W'(w_rsp_fill);
        end else begin
            if (w_accept) begin
                r_pc[r_alloc]     <= pc;
                r_filled[r_alloc] <= 1'b0;
                r_alloc           <= r_alloc + AW'(1);
            end
            if (w_rsp_fill) begin
                r_instr[r_fill]  <= imem_rsp_data;
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + AW'(1);
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + AW'(1);
            end
            r_occ  <= r_occ + CNT_W'(w_accept) - CNT_W'(w_pop);
            r_unf  <= r_unf + CNT_W'(w_accept) - CNT_W'(w_rsp_fill);
            r_drop <= r_drop - CNT_W'(w_rsp_drop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue (DEPTH=2)
// Rev 1.0
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc = 32'h0;
    logic [31:0] pc_next;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        rsp_en;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_q [$];
    logic [31:0] mem_q [$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pc_next        (pc_next),
        .imem_req_valid (req_valid),
        .imem_req_addr  (req_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    // PC register
    always @(posedge clk) pc <= rst_n ? pc_next : 32'h0;

    // Instruction memory: answers in order, first response the cycle after accept
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            if (req_valid && req_ready) mem_q.push_back(req_addr);
            if (rsp_en && mem_q.size() > 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= 32'hC0DE_0000 ^ mem_q.pop_front();
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every decode handshake pops one expected {pc, instr}
    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got id_pc %h expected no handshake", id_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_id_pc", id_pc, e[63:32]);
                chk("sb_id_instr", id_instr, e[31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_id(input logic [31:0] p, input logic [31:0] ins);
        exp_q.push_back({p, ins});
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req_ready      = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_en         = 1'b1;
        repeat (3) cyc();
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_pc_next", pc_next, 32'h0);
        rst_n = 1'b1;
    endtask

    // Wait for a request to be accepted at the coming edge, then stop fetching.
    task automatic accept_then_stop(input string name, input logic [31:0] addr);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_valid && req_ready) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (seen) chk(name, req_addr, addr);
        else begin
            n_total++;
            $display("FAIL %s: got no accept expected addr %h", name, addr);
        end
        cyc();
        req_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
        chk(name, 32'(exp_q.size()), 32'h0);
        repeat (3) cyc();
    endtask

    initial begin
        rsp_en = 1'b1;

        // 1: streaming fetch
        do_reset();
        req_ready = 1'b1; id_ready = 1'b1;
        expect_id(32'h0, 32'hC0DE_0000);
        expect_id(32'h4, 32'hC0DE_0004);
        expect_id(32'h8, 32'hC0DE_0008);
        #1; chk("t1_c0_req_valid", 32'(req_valid), 32'h1);
        chk("t1_c0_pc_next", pc_next, 32'h4);
        cyc(); #1;
        chk("t1_c1_pc_next", pc_next, 32'h8);
        chk("t1_c1_id_valid", 32'(id_valid), 32'h0);
        cyc(); #1;
        chk("t1_c2_full_req_valid", 32'(req_valid), 32'h0);
        chk("t1_c2_pc_next", pc_next, 32'h8);
        chk("t1_c2_id_pc", id_pc, 32'h0);
        cyc(); #1;
        chk("t1_c3_req_valid", 32'(req_valid), 32'h1);
        chk("t1_c3_pc_next", pc_next, 32'hC);
        chk("t1_c3_id_pc", id_pc, 32'h4);
        cyc();
        req_ready = 1'b0;
        #1; chk("t1_c4_pc_next_hold", pc_next, 32'hC);
        drain("t1_drain");

        // 2: decode back-pressure fills the queue
        do_reset();
        req_ready = 1'b1; id_ready = 1'b0;
        expect_id(32'h0, 32'hC0DE_0000);
        expect_id(32'h4, 32'hC0DE_0004);
        expect_id(32'h8, 32'hC0DE_0008);
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_full_req_valid", 32'(req_valid), 32'h0);
            chk("t2_full_pc_next", pc_next, 32'h8);
            chk("t2_stable_id_pc", id_pc, 32'h0);
            if (k < 2) cyc();
        end
        id_ready = 1'b1;
        cyc(); #1;
        chk("t2_c5_id_pc", id_pc, 32'h4);
        accept_then_stop("t2_refetch_addr", 32'h8);
        drain("t2_drain");

        // 3: memory stalls
        do_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_stall_req_valid", 32'(req_valid), 32'h1);
            chk("t3_stall_addr", req_addr, 32'h0);
            chk("t3_stall_pc_next", pc_next, 32'h0);
            cyc();
        end
        req_ready = 1'b1;
        expect_id(32'h0, 32'hC0DE_0000);
        #1; chk("t3_resume_pc_next", pc_next, 32'h4);
        cyc();
        req_ready = 1'b0;
        drain("t3_drain");

        // 4: redirect with two requests in flight
        do_reset();
        rsp_en = 1'b0; req_ready = 1'b1; id_ready = 1'b1;
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("t4_redir_pc_next", pc_next, 32'h100);
        chk("t4_redir_req_valid", 32'(req_valid), 32'h0);
        cyc();
        redirect_valid = 1'b0; rsp_en = 1'b1;
        expect_id(32'h100, 32'hC0DE_0100);
        #1;
        chk("t4_drop_credit_req_valid", 32'(req_valid), 32'h0);
        chk("t4_id_valid_after_redir", 32'(id_valid), 32'h0);
        accept_then_stop("t4_target_addr", 32'h100);
        drain("t4_drain");

        // 5: redirect coincides with a response and a decode handshake
        do_reset();
        req_ready = 1'b1; id_ready = 1'b1;
        cyc(); cyc();
        #1; chk("t5_pre_id_valid", 32'(id_valid), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("t5_redir_id_valid", 32'(id_valid), 32'h0);
        chk("t5_redir_pc_next", pc_next, 32'h200);
        cyc();
        redirect_valid = 1'b0;
        expect_id(32'h200, 32'hC0DE_0200);
        #1; chk("t5_req_valid", 32'(req_valid), 32'h1);
        accept_then_stop("t5_target_addr", 32'h200);
        drain("t5_drain");

        // 6: reset mid-operation, queue full with one response outstanding
        do_reset();
        req_ready = 1'b1; id_ready = 1'b0;
        cyc();
        rsp_en = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_id_valid", 32'(id_valid), 32'h0);
        chk("t6_rst_req_valid", 32'(req_valid), 32'h0);
        cyc(); #1;
        chk("t6_next_id_valid", 32'(id_valid), 32'h0);
        chk("t6_next_req_valid", 32'(req_valid), 32'h0);
        rst_n = 1'b1; rsp_en = 1'b1; id_ready = 1'b1;
        #1;
        chk("t6_rel_id_valid", 32'(id_valid), 32'h0);
        chk("t6_rel_id_pc", id_pc, 32'h0);
        chk("t6_rel_id_instr", id_instr, 32'h0);
        chk("t6_rel_pc_next", pc_next, 32'h4);
        expect_id(32'h0, 32'hC0DE_0000);
        accept_then_stop("t6_restart_addr", 32'h0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
